pipe_stage_chain: RTL and testbench

Parametrised elastic pipeline-register chain that generalises the fixed IF/ID and ID/EX stage registers of the MIPS pipeline. It carries a packed WIDTH-bit payload through STAGES registered stages, with a per-stage valid bit and valid/ready backpressure. It also provides a global hazard stall, a per-stage flush for branch squash, and bubble collapse. It sits between any two pipeline boundaries of the processor and exposes occupancy and squash statistics to the hazard/debug logic.

---
 rtl/pipe_stage_chain.sv | 113 +++++++++++
 tb/tb_pipe_stage_chain.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain: STAGES valid/ready stages with global stall,
// per-stage flush, bubble collapse, occupancy and saturating squash statistics.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             in_ready,
    input  logic                             stall,
    input  logic [STAGES-1:0]                flush_mask,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             out_ready,
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
    output logic [CNT_W-1:0]                 squash_count
);

    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int SUM_W = CNT_W + 6;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [CNT_W-1:0]  r_squash;

    logic [STAGES-1:0] w_ev;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_src_v;
    logic [WIDTH-1:0]  w_src_d [STAGES];
    logic [4:0]        w_occ_full;
    logic [4:0]        w_kill_cnt;

    function automatic logic [4:0] popcnt(input logic [STAGES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < STAGES; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [4:0]       b);
        logic [SUM_W-1:0] s;
        logic [SUM_W-1:0] lim;
        s   = SUM_W'(a) + SUM_W'(b);
        lim = SUM_W'({CNT_W{1'b1}});
        if (s > lim) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // A flushed stage counts as empty, so it can be refilled at the same edge
    // and lets the ready chain propagate through it (bubble collapse).
    always_comb begin
        logic acc;
        w_ev = r_valid & ~flush_mask;
        acc  = out_ready;
        w_rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc      = ~w_ev[i] | acc;
            w_rdy[i] = acc;
        end
    end

    always_comb begin
        w_src_v[0] = in_valid;
        w_src_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_src_v[i] = w_ev[i-1];
            w_src_d[i] = r_data[i-1];
        end
    end

    assign w_occ_full = popcnt(r_valid);
    assign w_kill_cnt = popcnt(r_valid & flush_mask);

    assign in_ready     = w_rdy[0] & ~stall & reset;
    assign out_valid    = w_ev[STAGES-1] & ~stall;
    assign out_data     = r_data[STAGES-1];
    assign occupancy    = OCC_W'(w_occ_full);
    assign squash_count = r_squash;

    // Stage registers: stall freezes movement but flush still clears content;
    // otherwise a ready stage loads its source, or a zero bubble if none.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= '0;
            r_squash <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_squash <= sat_add(r_squash, w_kill_cnt);
            for (int i = 0; i < STAGES; i++) begin
                if (stall) begin
                    r_valid[i] <= w_ev[i];
                    if (flush_mask[i]) begin
                        r_data[i] <= '0;
                    end
                end else if (w_rdy[i]) begin
                    r_valid[i] <= w_src_v[i];
                    r_data[i]  <= w_src_v[i] ? w_src_d[i] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, CNT_W=4): vector table for
// streaming/backpressure/stall/flush, hand sequences for async reset and saturation.
module tb_pipe_stage_chain;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        stall;
    logic [3:0]  flush_mask;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic [3:0]  squash_count;

    int checks   = 0;
    int failures = 0;

    pipe_stage_chain #(.WIDTH(32), .STAGES(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush_mask   (flush_mask),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .squash_count (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        st;
        logic [3:0]  fm;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        int          occ;
        int          sq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [31:0] id, input logic st,
                       input logic [3:0] fm, input logic ordy, input logic ov,
                       input logic [31:0] od, input logic ir, input int occ, input int sq);
        vec_t v;
        v.iv = iv; v.id = id; v.st = st; v.fm = fm; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.sq = sq;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic st,
                         input logic [3:0] fm, input logic ordy);
        in_valid   = iv;
        in_data    = id;
        stall      = st;
        flush_mask = fm;
        out_ready  = ordy;
    endtask

    initial begin
        int exp_sq;
        reset = 1'b0;
        drive(0, 0, 0, 4'h0, 0);

        // stream 1..8 with out_ready=1
        add(1, 32'h1, 0, 4'h0, 1,  0, 32'h0, 1, 0, 0);
        add(1, 32'h2, 0, 4'h0, 1,  0, 32'h0, 1, 1, 0);
        add(1, 32'h3, 0, 4'h0, 1,  0, 32'h0, 1, 2, 0);
        add(1, 32'h4, 0, 4'h0, 1,  0, 32'h0, 1, 3, 0);
        add(1, 32'h5, 0, 4'h0, 1,  1, 32'h1, 1, 4, 0);
        add(1, 32'h6, 0, 4'h0, 1,  1, 32'h2, 1, 4, 0);
        add(1, 32'h7, 0, 4'h0, 1,  1, 32'h3, 1, 4, 0);
        add(1, 32'h8, 0, 4'h0, 1,  1, 32'h4, 1, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h5, 1, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h6, 1, 3, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h7, 1, 2, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h8, 1, 1, 0);
        add(0, 32'h0, 0, 4'h0, 1,  0, 32'h0, 1, 0, 0);
        // backpressure and bubble collapse
        add(1, 32'hA, 0, 4'h0, 0,  0, 32'h0, 1, 0, 0);
        add(0, 32'h0, 0, 4'h0, 0,  0, 32'h0, 1, 1, 0);
        add(1, 32'hB, 0, 4'h0, 0,  0, 32'h0, 1, 1, 0);
        add(1, 32'hC, 0, 4'h0, 0,  0, 32'h0, 1, 2, 0);
        add(0, 32'h0, 0, 4'h0, 0,  1, 32'hA, 1, 3, 0);
        add(1, 32'hD, 0, 4'h0, 0,  1, 32'hA, 1, 3, 0);
        add(1, 32'hE, 0, 4'h0, 0,  1, 32'hA, 0, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'hA, 1, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'hB, 1, 3, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'hC, 1, 2, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'hD, 1, 1, 0);
        add(0, 32'h0, 0, 4'h0, 1,  0, 32'h0, 1, 0, 0);
        // stall with full chain; input offered during stall is refused
        add(1, 32'h10, 0, 4'h0, 0, 0, 32'h0, 1, 0, 0);
        add(1, 32'h11, 0, 4'h0, 0, 0, 32'h0, 1, 1, 0);
        add(1, 32'h12, 0, 4'h0, 0, 0, 32'h0, 1, 2, 0);
        add(1, 32'h13, 0, 4'h0, 0, 0, 32'h0, 1, 3, 0);
        add(1, 32'h99, 1, 4'h0, 1, 0, 32'h10, 0, 4, 0);
        add(1, 32'h99, 1, 4'h0, 1, 0, 32'h10, 0, 4, 0);
        add(1, 32'h99, 1, 4'h0, 1, 0, 32'h10, 0, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h10, 1, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h11, 1, 3, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h12, 1, 2, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h13, 1, 1, 0);
        add(0, 32'h0, 0, 4'h0, 1,  0, 32'h0, 1, 0, 0);
        // flush of stages 0 and 1 while refilling stage 0
        add(1, 32'h20, 0, 4'h0, 0, 0, 32'h0, 1, 0, 0);
        add(1, 32'h21, 0, 4'h0, 0, 0, 32'h0, 1, 1, 0);
        add(1, 32'h22, 0, 4'h0, 0, 0, 32'h0, 1, 2, 0);
        add(1, 32'h23, 0, 4'h0, 0, 0, 32'h0, 1, 3, 0);
        add(1, 32'h24, 0, 4'h3, 0, 1, 32'h20, 1, 4, 0);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h20, 1, 3, 2);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h21, 1, 2, 2);
        add(0, 32'h0, 0, 4'h0, 1,  0, 32'h0, 1, 1, 2);
        add(0, 32'h0, 0, 4'h0, 1,  1, 32'h24, 1, 1, 2);
        add(0, 32'h0, 0, 4'h0, 1,  0, 32'h0, 1, 0, 2);

        repeat (2) @(negedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.occupancy", 32'(occupancy), 32'd0);
        chk("rst.squash", 32'(squash_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].iv, vecs[k].id, vecs[k].st, vecs[k].fm, vecs[k].ordy);
            #1;
            chk($sformatf("v%0d.out_valid", k), 32'(out_valid), 32'(vecs[k].ov));
            chk($sformatf("v%0d.out_data", k), out_data, vecs[k].od);
            chk($sformatf("v%0d.in_ready", k), 32'(in_ready), 32'(vecs[k].ir));
            chk($sformatf("v%0d.occupancy", k), 32'(occupancy), 32'(vecs[k].occ));
            chk($sformatf("v%0d.squash", k), 32'(squash_count), 32'(vecs[k].sq));
        end

        // asynchronous reset between clock edges while full
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 32'h40 + 32'(k), 0, 4'h0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 0);
        #1;
        chk("ar.occ_full", 32'(occupancy), 32'd4);
        chk("ar.out_data_full", out_data, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.out_valid", 32'(out_valid), 32'd0);
        chk("ar.occupancy", 32'(occupancy), 32'd0);
        chk("ar.in_ready", 32'(in_ready), 32'd0);
        chk("ar.out_data", out_data, 32'd0);
        chk("ar.squash", 32'(squash_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 4'h0, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("ar.post%0d.out_valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("ar.post%0d.occupancy", k), 32'(occupancy), 32'd0);
        end

        // saturating squash counter; round 1 flushes under stall
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                drive(1, 32'h30 + 32'(k), 0, 4'h0, 0);
            end
            @(negedge clk);
            drive(0, 0, (r == 1), 4'hF, 0);
            #1;
            chk($sformatf("sat.r%0d.occ_full", r), 32'(occupancy), 32'd4);
            @(negedge clk);
            drive(0, 0, 0, 4'h0, 0);
            #1;
            exp_sq = (4 * (r + 1) > 15) ? 15 : 4 * (r + 1);
            chk($sformatf("sat.r%0d.occ_empty", r), 32'(occupancy), 32'd0);
            chk($sformatf("sat.r%0d.out_valid", r), 32'(out_valid), 32'd0);
            chk($sformatf("sat.r%0d.squash", r), 32'(squash_count), 32'(exp_sq));
            if (r == 0) begin
                @(negedge clk);
                drive(0, 0, 0, 4'hF, 0);
                @(negedge clk);
                drive(0, 0, 0, 4'h0, 0);
                #1;
                chk("sat.empty_flush.squash", 32'(squash_count), 32'd4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
